slot_irq_ctrl: RTL

SLOT_IRQ_CTRL -- requirements
Module: slot_irq_ctrl

---
 rtl/slot_regs_pkg.sv | 27 ++
 rtl/slot_rr_arbiter.sv | 39 +++
 rtl/slot_irq_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/slot_regs_pkg.sv
// -----------------------------------------------------------------------------
// slot_regs_pkg
// Shared definitions for the slot interrupt controller:
//   - N_SLOTS       : number of I/O slots the register map is laid out for
//   - *_OFS         : base offsets of the per-slot register banks and vector
//   - arb_state_e   : arbiter FSM state encoding
// -----------------------------------------------------------------------------
package slot_regs_pkg;

    localparam int N_SLOTS = 8;

    // Each per-slot bank spans N_SLOTS consecutive addresses from its base.
    localparam logic [7:0] MASK_OFS  = 8'h20;
    localparam logic [7:0] CLEAR_OFS = 8'h28;
    localparam logic [7:0] PEND_OFS  = 8'h30;
    localparam logic [7:0] VEC_OFS   = 8'h38;

    // Bit position of the irq flag inside the vector register.
    localparam int VEC_IRQ_BIT = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/slot_rr_arbiter.sv
// -----------------------------------------------------------------------------
// slot_rr_arbiter
// Combinational round-robin search: returns the first asserted request
// starting at (ptr + 1) and wrapping, so the slot at ptr has lowest priority.
// N_REQ must be a power of two (the index arithmetic wraps naturally).
//
// Ports:
//   req     in  N_REQ   request vector (one bit per slot)
//   ptr     in  IDX_W   last served index
//   gnt_idx out IDX_W   selected index (0 when gnt_vld=0)
//   gnt_vld out 1       at least one request is asserted
// -----------------------------------------------------------------------------
module slot_rr_arbiter #(
    parameter int N_REQ = slot_regs_pkg::N_SLOTS,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        // Offset N_REQ wraps back to ptr itself, giving it the last chance.
        for (int i = 1; i <= N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/slot_irq_ctrl.sv
// -----------------------------------------------------------------------------
// slot_irq_ctrl
// Edge-triggered per-slot interrupt collector with a register interface and a
// round-robin arbiter that raises a single host irq for one slot at a time.
//
// Ports:
//   sys_clk    in   1               clock, rising edge
//   sys_rst_n  in   1               asynchronous active-low reset
//   slot_in    in   N_SLOTS*DATA_W  synchronised slot pins, slot s at [s*DATA_W +: DATA_W]
//   reg_we     in   1               register write strobe
//   reg_re     in   1               register read strobe
//   reg_addr   in   ADDR_W          register address
//   reg_wdata  in   DATA_W          write data
//   reg_rdata  out  DATA_W          read data, valid with reg_ack
//   reg_ack    out  1               one-cycle acknowledge, one cycle after a strobe
//   irq        out  1               interrupt request to host
//
// Register map: 0x20+s mask (RW), 0x28+s W1C clear (reads 0),
//               0x30+s pending (RO), 0x38 vector {irq, 12'b0, grant[2:0]}.
//
// Build option: define SLOT_IRQ_BOTHEDGE_EN to latch falling edges as well as
// rising edges into pending; by default only rising edges are latched.
// -----------------------------------------------------------------------------
module slot_irq_ctrl #(
    parameter int N_SLOTS = 8,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [N_SLOTS*DATA_W-1:0] slot_in,
    input  logic                      reg_we,
    input  logic                      reg_re,
    input  logic [ADDR_W-1:0]         reg_addr,
    input  logic [DATA_W-1:0]         reg_wdata,
    output logic [DATA_W-1:0]         reg_rdata,
    output logic                      reg_ack,
    output logic                      irq
);
    import slot_regs_pkg::*;

    localparam int IDX_W = $clog2(N_SLOTS);

    function automatic logic [ADDR_W-1:0] reg_ofs(input logic [7:0] base, input int s);
        return ADDR_W'(int'(base) + s);
    endfunction

    logic [N_SLOTS-1:0][DATA_W-1:0] mask_q, mask_d;
    logic [N_SLOTS-1:0][DATA_W-1:0] pending_q, pending_d;
    logic [N_SLOTS-1:0][DATA_W-1:0] clr, evt;
    logic [N_SLOTS*DATA_W-1:0]      prev_q, prev_d;
    logic                           prev_vld_q, prev_vld_d;
    logic                           reg_ack_q, reg_ack_d;
    logic [DATA_W-1:0]              rdata_q, rdata_d;
    logic [DATA_W-1:0]              vec;
    logic [N_SLOTS-1:0]             active;

    arb_state_e                     state_q;
    logic [IDX_W-1:0]               grant_q;
    logic [IDX_W-1:0]               ptr_q;
    logic                           irq_q;

    logic [IDX_W-1:0]               arb_idx;
    logic                           arb_vld;

    // Edge detection. prev_vld_q stays low for the first clock after reset so
    // that pins already high at release are absorbed into prev_q silently.
    always_comb begin
        prev_d     = slot_in;
        prev_vld_d = 1'b1;
        evt        = '0;
        if (prev_vld_q) begin
`ifdef SLOT_IRQ_BOTHEDGE_EN
            evt = slot_in ^ prev_q;
`else
            evt = slot_in & ~prev_q;
`endif
        end
    end

    always_comb begin
        vec                 = '0;
        vec[VEC_IRQ_BIT]    = irq_q;
        vec[IDX_W-1:0]      = grant_q;
    end

    // Register decode. A write takes precedence over a simultaneous read and
    // then returns zero data; unmatched addresses fall through to zero.
    always_comb begin
        mask_d    = mask_q;
        clr       = '0;
        rdata_d   = '0;
        reg_ack_d = reg_we | reg_re;
        for (int s = 0; s < N_SLOTS; s++) begin
            if (reg_we && reg_addr == reg_ofs(MASK_OFS, s)) begin
                mask_d[s] = reg_wdata;
            end
            if (reg_we && reg_addr == reg_ofs(CLEAR_OFS, s)) begin
                clr[s] = reg_wdata;
            end
            if (reg_re && !reg_we && reg_addr == reg_ofs(MASK_OFS, s)) begin
                rdata_d = mask_q[s];
            end
            if (reg_re && !reg_we && reg_addr == reg_ofs(PEND_OFS, s)) begin
                rdata_d = pending_q[s];
            end
        end
        if (reg_re && !reg_we && reg_addr == reg_ofs(VEC_OFS, 0)) begin
            rdata_d = vec;
        end
    end

    // New events are OR-ed in after the clear so a coincident set wins.
    always_comb begin
        pending_d = (pending_q & ~clr) | evt;
        for (int s = 0; s < N_SLOTS; s++) begin
            active[s] = |(pending_q[s] & mask_q[s]);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mask_q     <= '0;
            pending_q  <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            reg_ack_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            mask_q     <= mask_d;
            pending_q  <= pending_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            reg_ack_q  <= reg_ack_d;
            rdata_q    <= rdata_d;
        end
    end

    slot_rr_arbiter #(
        .N_REQ (N_SLOTS),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (active),
        .ptr     (ptr_q),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Arbiter FSM. ptr resets to the last slot so slot 0 is searched first.
    // While in HOLD, new activity on other slots only accumulates in pending.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= IDX_W'(N_SLOTS - 1);
            irq_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_vld) begin
                        grant_q <= arb_idx;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    irq_q   <= 1'b1;
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!active[grant_q]) begin
                        irq_q   <= 1'b0;
                        ptr_q   <= grant_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    irq_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign reg_ack   = reg_ack_q;
    assign reg_rdata = rdata_q;
    assign irq       = irq_q;

endmodule
